// File: rtl/icache_pkg.sv
// Shared types and width helpers for the two-way instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    function automatic int unsigned offset_width(input int unsigned words);
        return $clog2(words) + 2;
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned index_w,
                                              input int unsigned words);
        return addr_w - index_w - offset_width(words);
    endfunction

    // Word-select field width; kept at least 1 so single-word lines still get a legal port.
    function automatic int unsigned sel_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag and data arrays, tag compare and word select.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH    = 6,
    parameter int unsigned TAG_WIDTH      = 23,
    parameter int unsigned WORDS_PER_LINE = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rdy,
    input  logic                             flush,
    input  logic [INDEX_WIDTH-1:0]           rd_index,
    input  logic [TAG_WIDTH-1:0]             rd_tag,
    input  logic [sel_width(WORDS_PER_LINE)-1:0] rd_sel,
    input  logic                             wr_en,
    input  logic [INDEX_WIDTH-1:0]           wr_index,
    input  logic [TAG_WIDTH-1:0]             wr_tag,
    input  logic [32*WORDS_PER_LINE-1:0]     wr_data,
    output logic                             hit,
    output logic                             line_valid,
    output logic [31:0]                      word
);

    localparam int unsigned SETS = 2 ** INDEX_WIDTH;

    logic [SETS-1:0]                       valid;
    logic [TAG_WIDTH-1:0]                  tag_mem  [SETS];
    logic [WORDS_PER_LINE-1:0][31:0]       data_mem [SETS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (rdy) begin
            if (flush) begin
                valid <= '0;
            end else if (wr_en) begin
                valid[wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign line_valid = valid[rd_index];
    assign hit        = line_valid && (tag_mem[rd_index] == rd_tag);
    assign word       = data_mem[rd_index][rd_sel];

endmodule

// File: rtl/instr_cache_2way.sv
// Two-way set-associative instruction cache with per-set LRU and line refill FSM.
// Define ICACHE_STATS_EN to add the stat_hits / stat_misses counters.
module instr_cache_2way
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORDS_PER_LINE = 2,
    parameter int unsigned INDEX_WIDTH    = 6
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         clear_signal,
    input  logic                         flush_signal,
    input  logic                         fetch_signal,
    input  logic [ADDR_WIDTH-1:0]        fetch_addr,
    output logic                         fetch_done,
    output logic [31:0]                  fetch_instr,
    output logic                         mem_signal,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_done,
    input  logic [32*WORDS_PER_LINE-1:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                  stat_hits,
    output logic [31:0]                  stat_misses
`endif
);

    localparam int unsigned OFFSET_WIDTH = offset_width(WORDS_PER_LINE);
    localparam int unsigned TAG_WIDTH    = tag_width(ADDR_WIDTH, INDEX_WIDTH, WORDS_PER_LINE);
    localparam int unsigned SEL_WIDTH    = sel_width(WORDS_PER_LINE);
    localparam int unsigned SETS         = 2 ** INDEX_WIDTH;

    state_t                 state, next_state;
    logic [INDEX_WIDTH-1:0] index, miss_index;
    logic [TAG_WIDTH-1:0]   tag, miss_tag;
    logic [SEL_WIDTH-1:0]   sel;
    logic                   hit0, hit1, valid0, valid1;
    logic [31:0]            word0, word1;
    logic [SETS-1:0]        lru;
    logic                   victim, miss_way;
    logic                   start_miss, refill;
    logic [1:0]             unused_addr_bits;

    assign index            = fetch_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign tag              = fetch_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign unused_addr_bits = fetch_addr[1:0];

    generate
        if (WORDS_PER_LINE > 1) begin : g_sel
            assign sel = fetch_addr[OFFSET_WIDTH-1:2];
        end else begin : g_nosel
            assign sel = '0;
        end
    endgenerate

    icache_way #(
        .INDEX_WIDTH    (INDEX_WIDTH),
        .TAG_WIDTH      (TAG_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_way0 (
        .clk(clk_in), .rst_n(rst_n_in), .rdy(rdy_in), .flush(flush_signal),
        .rd_index(index), .rd_tag(tag), .rd_sel(sel),
        .wr_en(refill && !miss_way), .wr_index(miss_index), .wr_tag(miss_tag), .wr_data(mem_data),
        .hit(hit0), .line_valid(valid0), .word(word0)
    );

    icache_way #(
        .INDEX_WIDTH    (INDEX_WIDTH),
        .TAG_WIDTH      (TAG_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_way1 (
        .clk(clk_in), .rst_n(rst_n_in), .rdy(rdy_in), .flush(flush_signal),
        .rd_index(index), .rd_tag(tag), .rd_sel(sel),
        .wr_en(refill && miss_way), .wr_index(miss_index), .wr_tag(miss_tag), .wr_data(mem_data),
        .hit(hit1), .line_valid(valid1), .word(word1)
    );

    assign fetch_done  = fetch_signal && (hit0 || hit1);
    assign fetch_instr = hit0 ? word0 : (hit1 ? word1 : '0);
    assign victim      = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[index]);
    assign mem_signal  = (state == MISS);

    always_comb begin
        next_state = state;
        start_miss = 1'b0;
        refill     = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_signal && !fetch_done && !clear_signal && !flush_signal) begin
                    next_state = MISS;
                    start_miss = 1'b1;
                end
            end
            MISS: begin
                if (clear_signal || flush_signal) begin
                    next_state = IDLE;
                end else if (mem_done) begin
                    next_state = IDLE;
                    refill     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            mem_addr   <= '0;
            miss_index <= '0;
            miss_tag   <= '0;
            miss_way   <= 1'b0;
        end else if (rdy_in) begin
            state <= next_state;
            if (start_miss) begin
                mem_addr   <= {fetch_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                miss_index <= index;
                miss_tag   <= tag;
                miss_way   <= victim;
            end
        end
    end

    // LRU bit holds the victim way; a refill to the same set overrides a concurrent hit update.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            lru <= '0;
        end else if (rdy_in) begin
            if (fetch_done) begin
                lru[index] <= hit0;
            end
            if (refill) begin
                lru[miss_index] <= !miss_way;
            end
        end
    end

    assert property (@(posedge clk_in) disable iff (!rst_n_in) !(fetch_signal && hit0 && hit1));

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (rdy_in) begin
            if (fetch_done) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (start_miss) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_cache_2way.sv
// Directed self-checking bench for instr_cache_2way (default parameters).
module tb_instr_cache_2way;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        clear_signal;
    logic        flush_signal;
    logic        fetch_signal;
    logic [31:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        mem_signal;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [63:0] mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int total = 0;
    int bad   = 0;

    instr_cache_2way #(
        .ADDR_WIDTH     (32),
        .WORDS_PER_LINE (2),
        .INDEX_WIDTH    (6)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .rdy_in       (rdy_in),
        .clear_signal (clear_signal),
        .flush_signal (flush_signal),
        .fetch_signal (fetch_signal),
        .fetch_addr   (fetch_addr),
        .fetch_done   (fetch_done),
        .fetch_instr  (fetch_instr),
        .mem_signal   (mem_signal),
        .mem_addr     (mem_addr),
        .mem_done     (mem_done),
        .mem_data     (mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses)
`endif
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
    endtask

    // Drives a miss on an address known to be absent, refilled one cycle after entering MISS.
    task automatic fill(input logic [31:0] addr, input logic [63:0] line);
        fetch_signal = 1'b1;
        fetch_addr   = addr;
        tick();
        fetch_signal = 1'b0;
        mem_done     = 1'b1;
        mem_data     = line;
        tick();
        mem_done     = 1'b0;
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0; rdy_in = 1'b0; mem_done = 1'b1;
        fetch_signal = 1'b1; fetch_addr = 32'h0;
        tick(); tick();
        rst_n_in = 1'b1; rdy_in = 1'b1; mem_done = 1'b0;
        #1;
        total++; if (mem_signal !== 1'b0) begin bad++; $display("FAIL reset_mem_signal: got %0b want 0", mem_signal); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
        total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL reset_fetch_done: got %0b want 0", fetch_done); end
        total++; if (fetch_instr !== 32'h0) begin bad++; $display("FAIL reset_fetch_instr: got %h want 00000000", fetch_instr); end
        fetch_signal = 1'b0;
    endtask

    task automatic test_cold_miss;
        fetch_signal = 1'b1; fetch_addr = 32'h0000_1004;
        #1;
        total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL cold_first_done: got %0b want 0", fetch_done); end
        tick();
        fetch_signal = 1'b0;
        #1;
        total++; if (mem_signal !== 1'b1) begin bad++; $display("FAIL cold_mem_signal: got %0b want 1", mem_signal); end
        total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL cold_mem_addr: got %h want 00001000", mem_addr); end
        mem_done = 1'b1; mem_data = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        fetch_signal = 1'b1; fetch_addr = 32'h0000_1004;
        #1;
        total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL cold_done_same_cycle: got %0b want 0", fetch_done); end
        tick();
        mem_done = 1'b0;
        #1;
        total++; if (mem_signal !== 1'b0) begin bad++; $display("FAIL cold_mem_signal_drop: got %0b want 0", mem_signal); end
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'hBBBB_BBBB) begin bad++; $display("FAIL cold_hit_word1: got done=%0b instr=%h want 1 bbbbbbbb", fetch_done, fetch_instr); end
        fetch_addr = 32'h0000_1000;
        #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'hAAAA_AAAA) begin bad++; $display("FAIL cold_hit_word0: got done=%0b instr=%h want 1 aaaaaaaa", fetch_done, fetch_instr); end
        fetch_signal = 1'b0;
    endtask

    task automatic test_lru;
        do_reset();
        fill(32'h0000_0000, {32'h1111_0001, 32'h1111_0000});
        fill(32'h0000_0200, {32'h2222_0001, 32'h2222_0000});
        fill(32'h0000_0400, {32'h3333_0001, 32'h3333_0000});
        fetch_signal = 1'b1; fetch_addr = 32'h0000_0000; #1;
        total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL lru_evict_first: got %0b want 0", fetch_done); end
        fetch_addr = 32'h0000_0404; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h3333_0001) begin bad++; $display("FAIL lru_third_hit: got done=%0b instr=%h want 1 33330001", fetch_done, fetch_instr); end
        fetch_addr = 32'h0000_0200; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h2222_0000) begin bad++; $display("FAIL lru_touch: got done=%0b instr=%h want 1 22220000", fetch_done, fetch_instr); end
        tick();
        fetch_signal = 1'b0;
        fill(32'h0000_0000, {32'h4444_0001, 32'h4444_0000});
        fetch_signal = 1'b1; fetch_addr = 32'h0000_0400; #1;
        total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL lru_evict_lru: got %0b want 0", fetch_done); end
        fetch_addr = 32'h0000_0204; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h2222_0001) begin bad++; $display("FAIL lru_mru_kept: got done=%0b instr=%h want 1 22220001", fetch_done, fetch_instr); end
        fetch_addr = 32'h0000_0000; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h4444_0000) begin bad++; $display("FAIL lru_refilled: got done=%0b instr=%h want 1 44440000", fetch_done, fetch_instr); end
        fetch_signal = 1'b0;
    endtask

    task automatic test_alias;
        do_reset();
        fill(32'h0001_0000, {32'h5555_0001, 32'h5555_0000});
        fetch_signal = 1'b1; fetch_addr = 32'h0000_0000; #1;
        total++; if (fetch_done !== 1'b0 || fetch_instr !== 32'h0) begin bad++; $display("FAIL alias_miss: got done=%0b instr=%h want 0 00000000", fetch_done, fetch_instr); end
        fetch_addr = 32'h0001_0004; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h5555_0001) begin bad++; $display("FAIL alias_hit: got done=%0b instr=%h want 1 55550001", fetch_done, fetch_instr); end
        fetch_signal = 1'b0;
    endtask

    task automatic test_abort;
        fetch_signal = 1'b1; fetch_addr = 32'h0000_2000;
        tick();
        fetch_signal = 1'b0; #1;
        total++; if (mem_signal !== 1'b1 || mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL abort_req: got sig=%0b addr=%h want 1 00002000", mem_signal, mem_addr); end
        clear_signal = 1'b1; mem_done = 1'b1; mem_data = {32'h6666_0001, 32'h6666_0000};
        tick();
        clear_signal = 1'b0; mem_done = 1'b0; #1;
        total++; if (mem_signal !== 1'b0) begin bad++; $display("FAIL abort_drop: got %0b want 0", mem_signal); end
        fetch_signal = 1'b1; fetch_addr = 32'h0000_2000; #1;
        total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL abort_not_written: got %0b want 0", fetch_done); end
        tick();
        fetch_signal = 1'b0; #1;
        total++; if (mem_signal !== 1'b1) begin bad++; $display("FAIL abort_remiss: got %0b want 1", mem_signal); end
        mem_done = 1'b1; mem_data = {32'h7777_0001, 32'h7777_0000};
        tick();
        mem_done = 1'b0;
        fetch_signal = 1'b1; fetch_addr = 32'h0000_2000; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h7777_0000) begin bad++; $display("FAIL abort_refill: got done=%0b instr=%h want 1 77770000", fetch_done, fetch_instr); end
        fetch_signal = 1'b0;
    endtask

    task automatic test_stall;
        fetch_signal = 1'b1; fetch_addr = 32'h0000_300C;
        tick();
        rdy_in = 1'b0; mem_done = 1'b1; flush_signal = 1'b1;
        mem_data = {32'h8888_0001, 32'h8888_0000};
        fetch_addr = 32'h0000_2000;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (mem_signal !== 1'b1 || mem_addr !== 32'h0000_3008) begin bad++; $display("FAIL stall_hold[%0d]: got sig=%0b addr=%h want 1 00003008", i, mem_signal, mem_addr); end
        end
        rdy_in = 1'b1; mem_done = 1'b0; flush_signal = 1'b0;
        fetch_addr = 32'h0000_2004; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h7777_0001) begin bad++; $display("FAIL stall_no_flush: got done=%0b instr=%h want 1 77770001", fetch_done, fetch_instr); end
        fetch_signal = 1'b0;
        tick();
        total++; if (mem_signal !== 1'b1) begin bad++; $display("FAIL stall_still_miss: got %0b want 1", mem_signal); end
        mem_done = 1'b1; mem_data = {32'h9999_0001, 32'h9999_0000};
        tick();
        mem_done = 1'b0;
        fetch_signal = 1'b1; fetch_addr = 32'h0000_300C; #1;
        total++; if (fetch_done !== 1'b1 || fetch_instr !== 32'h9999_0001) begin bad++; $display("FAIL stall_refill: got done=%0b instr=%h want 1 99990001", fetch_done, fetch_instr); end
        fetch_signal = 1'b0;
    endtask

    task automatic test_flush;
        logic [31:0] addrs [4];
        logic [31:0] w0;
        addrs = '{32'h0000_4000, 32'h0000_4008, 32'h0000_4010, 32'h0000_4018};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w0 = 32'hC000_0000 + 32'(2 * i);
            fill(addrs[i], {w0 + 32'd1, w0});
        end
        for (int i = 0; i < 4; i++) begin
            w0 = 32'hC000_0000 + 32'(2 * i);
            fetch_signal = 1'b1; fetch_addr = addrs[i]; #1;
            total++; if (fetch_done !== 1'b1 || fetch_instr !== w0) begin bad++; $display("FAIL flush_prefill[%0d]: got done=%0b instr=%h want 1 %h", i, fetch_done, fetch_instr, w0); end
            tick();
            fetch_signal = 1'b0;
        end
        flush_signal = 1'b1;
        tick();
        flush_signal = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch_signal = 1'b1; fetch_addr = addrs[i]; #1;
            total++; if (fetch_done !== 1'b0) begin bad++; $display("FAIL flush_miss[%0d]: got %0b want 0", i, fetch_done); end
            fetch_signal = 1'b0;
        end
`ifdef ICACHE_STATS_EN
        total++; if (stat_hits !== 32'd4) begin bad++; $display("FAIL stats_hits: got %0d want 4", stat_hits); end
        total++; if (stat_misses !== 32'd4) begin bad++; $display("FAIL stats_misses: got %0d want 4", stat_misses); end
`endif
    endtask

    initial begin
        rst_n_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0; flush_signal = 1'b0;
        fetch_signal = 1'b0; fetch_addr = '0; mem_done = 1'b0; mem_data = '0;
        test_reset();
        test_cold_miss();
        test_lru();
        test_alias();
        test_abort();
        test_stall();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
